sctag_jbi_iq_rcv: RTL

//  Sctag-side receiver for the JBI request stream, directly downstream of the JBI->sctag1 repeater flops.

---
 rtl/sctag_jbi_iq_rcv.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/sctag_jbi_iq_rcv.sv
// JBI request receiver: assembles RD/WR8 beats into packets and queues them for the sctag pipe.
// Define SCTAG_IQ_BYPASS_EN to forward a completing packet straight to the head when the queue is empty.
module sctag_jbi_iq_rcv #(
    parameter int IQ_DEPTH = 4,
    parameter int PTR_W    = 2
) (
    input  logic        rclk,
    input  logic        arst_l,
    input  logic [31:0] jbi_sctag_req_d1,
    input  logic        jbi_sctag_req_vld_d1,
    input  logic        iq_rdy,
    output logic        iq_vld,
    output logic [31:0] iq_hdr,
    output logic [63:0] iq_data,
    output logic        sctag_jbi_iq_dequeue,
    output logic        iq_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA0 = 2'd1,
        DATA1 = 2'd2
    } st_t;

    localparam logic [2:0]     TYP_RD  = 3'b001;
    localparam logic [2:0]     TYP_WR8 = 3'b010;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(IQ_DEPTH);
    localparam logic [PTR_W:0] ONE_C   = (PTR_W + 1)'(1);

    st_t state, state_nxt;

    logic [31:0] hdr_q;
    logic [31:0] beat1_q;
    logic [31:0] mem_hdr  [IQ_DEPTH];
    logic [63:0] mem_data [IQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [31:0] last_hdr;
    logic [63:0] last_data;
    logic        err_q;

    logic        vld;
    logic [31:0] req;
    logic        is_rd;
    logic        is_wr8;
    logic        lat_hdr;
    logic        lat_b1;
    logic        cpl;
    logic        bad_beat;
    logic [31:0] cpl_hdr;
    logic [63:0] cpl_data;

    logic fifo_vld;
    logic full;
    logic pop;
    logic fifo_pop;
    logic push_req;
    logic push;
    logic drop;

    assign vld    = jbi_sctag_req_vld_d1;
    assign req    = jbi_sctag_req_d1;
    assign is_rd  = (req[31:29] == TYP_RD);
    assign is_wr8 = (req[31:29] == TYP_WR8);

    // FSM: state register
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = IDLE;
        unique case (state)
            IDLE:    state_nxt = (vld && is_wr8) ? DATA0 : IDLE;
            DATA0:   state_nxt = vld ? DATA1 : IDLE;
            DATA1:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: beat decode
    always_comb begin
        lat_hdr  = 1'b0;
        lat_b1   = 1'b0;
        cpl      = 1'b0;
        bad_beat = 1'b0;
        unique case (state)
            IDLE: begin
                if (vld) begin
                    unique case (1'b1)
                        is_rd:   cpl      = 1'b1;
                        is_wr8:  lat_hdr  = 1'b1;
                        default: bad_beat = 1'b1;
                    endcase
                end
            end
            DATA0: begin
                lat_b1   = vld;
                bad_beat = ~vld;
            end
            DATA1: begin
                cpl      = vld;
                bad_beat = ~vld;
            end
            default: ;
        endcase
    end

    assign cpl_hdr  = (state == IDLE) ? req : hdr_q;
    assign cpl_data = (state == IDLE) ? 64'd0 : {beat1_q, req};

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            hdr_q   <= '0;
            beat1_q <= '0;
        end else begin
            if (lat_hdr) hdr_q <= req;
            if (lat_b1) beat1_q <= req;
        end
    end

    assign fifo_vld = (count != '0);
    assign full     = (count == DEPTH_C);

`ifdef SCTAG_IQ_BYPASS_EN
    logic byp;
    assign byp      = cpl & ~fifo_vld;
    assign iq_vld   = fifo_vld | byp;
    assign pop      = iq_vld & iq_rdy;
    assign fifo_pop = pop & fifo_vld;
    assign push_req = cpl & ~(byp & iq_rdy);

    always_comb begin
        iq_hdr  = last_hdr;
        iq_data = last_data;
        if (fifo_vld) begin
            iq_hdr  = mem_hdr[rd_ptr];
            iq_data = mem_data[rd_ptr];
        end else if (byp) begin
            iq_hdr  = cpl_hdr;
            iq_data = cpl_data;
        end
    end
`else
    assign iq_vld   = fifo_vld;
    assign pop      = iq_vld & iq_rdy;
    assign fifo_pop = pop;
    assign push_req = cpl;
    assign iq_hdr   = fifo_vld ? mem_hdr[rd_ptr] : last_hdr;
    assign iq_data  = fifo_vld ? mem_data[rd_ptr] : last_data;
`endif

    // a full queue still takes the packet if the head leaves this cycle
    assign push = push_req & (~full | fifo_pop);
    assign drop = push_req & ~push;

    assign sctag_jbi_iq_dequeue = pop;
    assign iq_err               = err_q;

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                mem_hdr[i]  <= '0;
                mem_data[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_hdr[wr_ptr]  <= cpl_hdr;
                mem_data[wr_ptr] <= cpl_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, fifo_pop})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
        end
    end

    // head value shown while empty is the last one presented
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            last_hdr  <= '0;
            last_data <= '0;
            err_q     <= 1'b0;
        end else begin
            if (iq_vld) begin
                last_hdr  <= iq_hdr;
                last_data <= iq_data;
            end
            err_q <= bad_beat | drop;
        end
    end

endmodule
